// File: rtl/avalon_st_pkg.sv
// Shared types and helpers for the Avalon-ST source: FSM state encoding,
// default bus geometry and the byte-length to beat-count conversion.
package avalon_st_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int AST_WIDTH   = 64;
  localparam int AST_SYMBOLS = AST_WIDTH / 8;

  // Number of beats needed to carry len bytes, rounding a partial word up.
  function automatic int unsigned bytes_to_beats(input int unsigned len,
                                                 input int unsigned symbols = AST_SYMBOLS);
    return (len + symbols - 1) / symbols;
  endfunction

endpackage

// File: rtl/avalon_st_source.sv
// Avalon-ST packet transmitter: captures up to MAX_BEATS words on start and
// streams them out with sop/eop/empty under ready backpressure (readyLatency 0).
module avalon_st_source
  import avalon_st_pkg::*;
#(
  parameter int WIDTH       = AST_WIDTH,
  parameter int EMPTY_WIDTH = $clog2(WIDTH / 8),
  parameter int MAX_BEATS   = 4,
  parameter int LEN_WIDTH   = $clog2(MAX_BEATS * WIDTH / 8 + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [MAX_BEATS-1:0][WIDTH-1:0]  pkt_data,
  input  logic [LEN_WIDTH-1:0]             pkt_len,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic [WIDTH-1:0]                 data,
  output logic                             valid,
  input  logic                             ready,
  output logic                             sop,
  output logic                             eop,
  output logic [EMPTY_WIDTH-1:0]           empty,
  output state_e                           dbg_state
);

  localparam int SYMBOLS = WIDTH / 8;
  localparam int IDX_W   = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_BEATS * SYMBOLS);

  // Handshake: a beat moves on a rising edge with valid && ready. Once valid
  // is raised, data/sop/eop/empty stay frozen until that beat is accepted.

  state_e                          r_state;
  state_e                          w_next;
  logic [MAX_BEATS-1:0][WIDTH-1:0] r_words;
  logic [IDX_W-1:0]                r_idx;
  logic [IDX_W-1:0]                r_last;
  logic [EMPTY_WIDTH-1:0]          r_empty;
  logic [WIDTH-1:0]                r_data;
  logic                            r_done;
  logic                            r_err;

  logic                            w_len_ok;
  logic                            w_capture;
  logic                            w_xfer;
  logic                            w_eop;
  logic [IDX_W-1:0]                w_idx_nxt;
  int unsigned                     w_beats;
  logic [LEN_WIDTH-1:0]            w_empty_full;

  assign w_len_ok     = (pkt_len != '0) && (pkt_len <= MAX_LEN);
  assign w_capture    = (r_state == IDLE) && start && w_len_ok;
  assign w_xfer       = (r_state == SEND) && ready;
  assign w_eop        = (r_idx == r_last);
  assign w_idx_nxt    = r_idx + IDX_W'(1);
  assign w_beats      = bytes_to_beats(32'(pkt_len), SYMBOLS);
  // Padding bytes on the last beat; the difference always fits in LEN_WIDTH.
  assign w_empty_full = LEN_WIDTH'(w_beats * SYMBOLS) - pkt_len;

  assign data      = r_data;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_capture) w_next = SEND;
      SEND:    if (w_xfer && w_eop) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    valid = 1'b0;
    busy  = 1'b0;
    sop   = 1'b0;
    eop   = 1'b0;
    empty = '0;
    if (r_state == SEND) begin
      valid = 1'b1;
      busy  = 1'b1;
      sop   = (r_idx == '0);
      eop   = w_eop;
      empty = w_eop ? r_empty : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_words <= '0;
      r_idx   <= '0;
      r_last  <= '0;
      r_empty <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= w_xfer && w_eop;
      r_err  <= (r_state == IDLE) && start && !w_len_ok;
      if (w_capture) begin
        r_words <= pkt_data;
        r_idx   <= '0;
        r_last  <= IDX_W'(w_beats - 1);
        r_empty <= EMPTY_WIDTH'(w_empty_full);
        r_data  <= pkt_data[0];
      end else if (w_xfer && !w_eop) begin
        // data is registered so it keeps the eop word once valid drops
        r_idx  <= w_idx_nxt;
        r_data <= r_words[w_idx_nxt];
      end
    end
  end

endmodule

// File: tb/tb_avalon_st_source.sv
// Self-checking bench for avalon_st_source: scenario tasks push expected beats
// into a queue and a negedge monitor pops and compares every accepted beat.
module tb_avalon_st_source;
  import avalon_st_pkg::*;

  localparam int WIDTH       = 64;
  localparam int MAX_BEATS   = 4;
  localparam int EMPTY_WIDTH = $clog2(WIDTH / 8);
  localparam int LEN_WIDTH   = $clog2(MAX_BEATS * WIDTH / 8 + 1);
  localparam int SYMBOLS     = WIDTH / 8;
  localparam int EW          = WIDTH + 2 + EMPTY_WIDTH;

  typedef logic [MAX_BEATS-1:0][WIDTH-1:0] pkt_t;

  logic                   clk;
  logic                   rst;
  logic                   start;
  pkt_t                   pkt_data;
  logic [LEN_WIDTH-1:0]   pkt_len;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [WIDTH-1:0]       data;
  logic                   valid;
  logic                   ready;
  logic                   sop;
  logic                   eop;
  logic [EMPTY_WIDTH-1:0] empty;
  state_e                 dbg_state;

  int          checks   = 0;
  int          errors   = 0;
  int          xfer_cnt = 0;
  int          cyc      = 0;
  bit          bp_mode  = 0;
  logic [EW-1:0] exp_q[$];

  avalon_st_source #(
    .WIDTH(WIDTH), .EMPTY_WIDTH(EMPTY_WIDTH), .MAX_BEATS(MAX_BEATS), .LEN_WIDTH(LEN_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pkt_data(pkt_data), .pkt_len(pkt_len),
    .busy(busy), .done(done), .err(err), .data(data), .valid(valid), .ready(ready),
    .sop(sop), .eop(eop), .empty(empty), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / ready pattern ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      ready = bp_mode ? ((cyc % 5) != 0) : 1'b1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  logic [EW-1:0] beat, held, exp_b;
  bit            prev_stall, prev_eop_xfer;

  initial begin
    prev_stall    = 0;
    prev_eop_xfer = 0;
    held          = '0;
    forever begin
      @(negedge clk);
      beat = {data, sop, eop, empty};
      if (rst) begin
        prev_stall    = 0;
        prev_eop_xfer = 0;
      end else begin
        checks++;
        if (done !== prev_eop_xfer) begin
          errors++;
          $display("FAIL done_timing: got %b, required %b at %0t", done, prev_eop_xfer, $time);
        end
        if (prev_stall) begin
          checks++;
          if (valid !== 1'b1 || beat !== held) begin
            errors++;
            $display("FAIL stall_stable: got valid=%b beat=%h, required valid=1 beat=%h", valid, beat, held);
          end
        end
        if (!valid) begin
          checks++;
          if ({sop, eop, empty} !== '0) begin
            errors++;
            $display("FAIL idle_ctrl: got sop=%b eop=%b empty=%0d, required all 0", sop, eop, empty);
          end
        end
        if (valid && ready) begin
          xfer_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got %h, required no beat", beat);
          end else begin
            exp_b = exp_q.pop_front();
            if (beat !== exp_b) begin
              errors++;
              $display("FAIL beat: got {data,sop,eop,empty}=%h, required %h", beat, exp_b);
            end
          end
        end
        prev_stall    = valid && !ready;
        held          = beat;
        prev_eop_xfer = valid && ready && eop;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic pkt_t rand_pkt();
    pkt_t p;
    for (int i = 0; i < MAX_BEATS; i++) p[i] = {$urandom, $urandom};
    return p;
  endfunction

  task automatic push_expected(input pkt_t words, input int len);
    int beats = (len + SYMBOLS - 1) / SYMBOLS;
    for (int i = 0; i < beats; i++) begin
      logic                   last = (i == beats - 1);
      logic [EMPTY_WIDTH-1:0] emp  = last ? EMPTY_WIDTH'(beats * SYMBOLS - len) : '0;
      exp_q.push_back({words[i], (i == 0), last, emp});
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the edge that sampled start.
  task automatic drive_start(input pkt_t words, input int len, input bit expect_pkt);
    pkt_data = words;
    pkt_len  = LEN_WIDTH'(len);
    start    = 1'b1;
    if (expect_pkt) push_expected(words, len);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns in the first cycle where the packet has ended (the done cycle).
  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (!busy && exp_q.size() == 0) begin
        ok = 1;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pkt_data = '0; pkt_len = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({valid, busy, done, err, sop, eop} !== 6'b0 || empty !== '0 || data !== '0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got v=%b b=%b d=%b e=%b sop=%b eop=%b emp=%0d data=%h st=%0d, required all 0",
               valid, busy, done, err, sop, eop, empty, data, dbg_state);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_packet();
    pkt_t w;
    bit   ok;
    for (int i = 0; i < MAX_BEATS; i++) w[i] = WIDTH'(i + 1);
    drive_start(w, 32, 1);
    checks++;
    if (valid !== 1'b1 || sop !== 1'b1 || data !== 64'd1) begin
      errors++;
      $display("FAIL first_beat_latency: got v=%b sop=%b data=%h, required v=1 sop=1 data=1", valid, sop, data);
    end
    wait_idle(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_pkt_timeout: got busy=%b, required 0", busy); end
    checks++;
    if (done !== 1'b1 || data !== 64'd4) begin
      errors++;
      $display("FAIL full_pkt_done: got done=%b data=%h, required done=1 data=4", done, data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || valid !== 1'b0 || data !== 64'd4) begin
      errors++;
      $display("FAIL data_hold: got done=%b v=%b data=%h, required done=0 v=0 data=4", done, valid, data);
    end
  endtask

  task automatic test_short_packets();
    bit ok;
    drive_start(rand_pkt(), 13, 1);
    wait_idle(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL len13_timeout: got busy=%b, required 0", busy); end
    drive_start(rand_pkt(), 1, 1);
    checks++;
    if (valid !== 1'b1 || sop !== 1'b1 || eop !== 1'b1 || empty !== 3'd7) begin
      errors++;
      $display("FAIL single_beat: got v=%b sop=%b eop=%b empty=%0d, required 1 1 1 7", valid, sop, eop, empty);
    end
    wait_idle(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL len1_timeout: got busy=%b, required 0", busy); end
    for (int n = 0; n < 8; n++) begin
      bp_mode = $urandom_range(0, 1) == 1;
      drive_start(rand_pkt(), $urandom_range(1, MAX_BEATS * SYMBOLS), 1);
      wait_idle(60, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL random_pkt_timeout: pkt %0d got busy=%b, required 0", n, busy); end
    end
    bp_mode = 0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int base;
    bp_mode = 1;
    base    = xfer_cnt;
    drive_start(rand_pkt(), 32, 1);
    wait_idle(60, ok);
    bp_mode = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout: got busy=%b, required 0", busy); end
    checks++;
    if (xfer_cnt - base != 4) begin
      errors++;
      $display("FAIL bp_transfers: got %0d, required 4", xfer_cnt - base);
    end
  endtask

  task automatic test_illegal_len();
    int lens[2] = '{0, 33};
    foreach (lens[k]) begin
      drive_start(rand_pkt(), lens[k], 0);
      checks++;
      if (err !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL illegal_err: len=%0d got err=%b v=%b busy=%b, required 1 0 0", lens[k], err, valid, busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (err !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL illegal_after: len=%0d got err=%b v=%b busy=%b, required 0 0 0", lens[k], err, valid, busy);
      end
    end
  endtask

  task automatic test_start_during_send();
    bit ok;
    drive_start(rand_pkt(), 32, 1);
    @(posedge clk);
    #1;
    drive_start(rand_pkt(), 8, 0);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_while_busy: got err=%b busy=%b, required 0 1", err, busy);
    end
    wait_idle(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL busy_start_timeout: got busy=%b, required 0", busy); end
    @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start_launched: got v=%b busy=%b, required 0 0", valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    bit   ok;
    pkt_t b = rand_pkt();
    drive_start(rand_pkt(), 20, 1);
    wait_idle(20, ok);
    checks++;
    if (!ok || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_done: got ok=%b done=%b, required 1 1", ok, done);
    end
    drive_start(b, 32, 1);
    checks++;
    if (valid !== 1'b1 || sop !== 1'b1 || data !== b[0]) begin
      errors++;
      $display("FAIL b2b_second_sop: got v=%b sop=%b data=%h, required 1 1 %h", valid, sop, data, b[0]);
    end
    wait_idle(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_timeout: got busy=%b, required 0", busy); end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    drive_start(rand_pkt(), 32, 1);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || sop !== 1'b0 || eop !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b busy=%b sop=%b eop=%b, required 0 0 0 0", valid, busy, sop, eop);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done: got done=%b v=%b, required 0 0", done, valid);
      end
    end
    drive_start(rand_pkt(), 32, 1);
    wait_idle(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL post_reset_timeout: got busy=%b, required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_short_packets();
    test_backpressure();
    test_illegal_len();
    test_start_during_send();
    test_back_to_back();
    test_reset_mid_packet();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_beats: got %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
